// File: rtl/spi_master.sv
// spi_master: mode-0 SPI master, MSB first; host valid/ready byte in (tx_*), rx_data/rx_valid out, SCK/MOSI/MISO/SSEL pins, busy; define SPI_MASTER_LOOPBACK_EN to add a loopback input that feeds MOSI back into the receive path
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8,
  parameter int GAP_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic              loopback,
`endif
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_last,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              SCK,
  output logic              MOSI,
  input  logic              MISO,
  output logic              SSEL
);
  localparam int CMAX = CLK_DIV > GAP_CYC ? CLK_DIV : GAP_CYC;
  localparam int CW = $clog2(CMAX + 1);
  localparam int BW = $clog2(DATA_W);
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, WAIT, GAP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_W-1:0] tx_sh, rx_sh;
  logic last_q, miso_m, miso_s, rx_bit, accept, div_end, gap_end;
`ifdef SPI_MASTER_LOOPBACK_EN
  assign rx_bit = loopback ? MOSI : miso_s;
`else
  assign rx_bit = miso_s;
`endif
  assign accept = tx_valid && tx_ready;
  assign div_end = cnt == CW'(CLK_DIV - 1);
  assign gap_end = cnt == CW'(GAP_CYC - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      tx_sh <= '0;
      rx_sh <= '0;
      last_q <= 1'b0;
      miso_m <= 1'b0;
      miso_s <= 1'b0;
      tx_ready <= 1'b1;
      rx_data <= '0;
      rx_valid <= 1'b0;
      busy <= 1'b0;
      SCK <= 1'b0;
      MOSI <= 1'b0;
      SSEL <= 1'b1;
    end else begin
      miso_m <= MISO;
      miso_s <= miso_m;
      rx_valid <= 1'b0;
      cnt <= cnt + 1'b1;
      case (state)
        IDLE, WAIT: begin
          cnt <= '0;
          if (accept) begin
            state <= SETUP;
            bit_cnt <= '0;
            tx_sh <= tx_data;
            last_q <= tx_last;
            MOSI <= tx_data[DATA_W-1];
            SSEL <= 1'b0;
            tx_ready <= 1'b0;
            busy <= 1'b1;
          end
        end
        SETUP: if (div_end) begin
          state <= HIGH;
          cnt <= '0;
          SCK <= 1'b1;
        end
        HIGH: if (div_end) begin
          state <= LOW;
          cnt <= '0;
          SCK <= 1'b0;
          rx_sh <= {rx_sh[DATA_W-2:0], rx_bit};
          if (bit_cnt != BW'(DATA_W - 1)) begin
            tx_sh <= tx_sh << 1;
            MOSI <= tx_sh[DATA_W-2];
          end
        end
        LOW: if (div_end) begin
          cnt <= '0;
          if (bit_cnt == BW'(DATA_W - 1)) begin
            state <= HOLD;
            rx_data <= rx_sh;
            rx_valid <= 1'b1;
          end else begin
            state <= HIGH;
            bit_cnt <= bit_cnt + 1'b1;
            SCK <= 1'b1;
          end
        end
        HOLD: if (div_end) begin
          cnt <= '0;
          if (last_q) begin
            state <= GAP;
            SSEL <= 1'b1;
            MOSI <= 1'b0;
          end else begin
            state <= WAIT;
            tx_ready <= 1'b1;
          end
        end
        GAP: if (gap_end) begin
          state <= IDLE;
          cnt <= '0;
          tx_ready <= 1'b1;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed self-checking bench for spi_master with a mode-0 slave model and a CLK_DIV=2 instance
module tb_spi_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic tx_last = 1'b0, tx_valid = 1'b0;
  logic tx_ready, rx_valid, busy, sck, mosi, ssel;
  logic miso = 1'b0;
  logic [7:0] rx_data;
  logic [7:0] d2_data = '0;
  logic d2_last = 1'b0, d2_valid = 1'b0;
  logic d2_ready, d2_rxv, d2_busy, d2_sck, d2_mosi, d2_miso, d2_ssel;
  logic [7:0] d2_rx;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
`ifdef SPI_MASTER_LOOPBACK_EN
  assign d2_miso = 1'b0;
`else
  assign d2_miso = d2_mosi;
`endif
  spi_master u_dut (
    .clk(clk), .rst(rst),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .SCK(sck), .MOSI(mosi), .MISO(miso), .SSEL(ssel)
  );
  spi_master #(.CLK_DIV(2)) u_dut2 (
    .clk(clk), .rst(rst),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(1'b1),
`endif
    .tx_data(d2_data), .tx_last(d2_last), .tx_valid(d2_valid), .tx_ready(d2_ready),
    .rx_data(d2_rx), .rx_valid(d2_rxv), .busy(d2_busy),
    .SCK(d2_sck), .MOSI(d2_mosi), .MISO(d2_miso), .SSEL(d2_ssel)
  );
  logic [7:0] slave_data [0:31];
  logic [7:0] mosi_hist [0:31];
  logic [7:0] rx_hist [0:31];
  logic [7:0] s_sh = '0, s_mosi = '0;
  logic prev_ssel = 1'b1, prev_sck = 1'b0, prev_rxv = 1'b0, prev_rdy = 1'b1;
  int s_bits = 0, mosi_cnt = 0, rxv_cnt = 0, rxv_cyc = 0, sck_rises = 0, ssel_rises = 0;
  int hi_run = 0, lo_run = 0, hi_bad = 0, lo_bad = 0, lo_ssel = 0, hi_ssel = 0, ssel_run = 0, gap_seen = 0;
  always @(negedge clk) begin
    if (prev_ssel && !ssel) begin
      s_sh = slave_data[mosi_cnt];
      s_bits = 0;
      miso = s_sh[7];
    end
    if (!prev_ssel && ssel) begin
      ssel_run = lo_ssel;
      ssel_rises++;
      s_bits = 0;
    end
    lo_ssel = ssel ? 0 : lo_ssel + 1;
    hi_ssel = ssel ? hi_ssel + 1 : 0;
    if (!prev_sck && sck && !ssel) begin
      sck_rises++;
      if (s_bits != 0 && lo_run != 4) lo_bad++;
      s_mosi = {s_mosi[6:0], mosi};
      s_bits++;
      if (s_bits == 8) begin
        mosi_hist[mosi_cnt] = s_mosi;
        mosi_cnt++;
      end
    end
    if (prev_sck && !sck) begin
      if (hi_run != 4) hi_bad++;
      if (s_bits == 8) begin
        s_sh = slave_data[mosi_cnt];
        s_bits = 0;
      end else s_sh = s_sh << 1;
      miso = s_sh[7];
    end
    hi_run = sck ? hi_run + 1 : 0;
    lo_run = sck ? 0 : lo_run + 1;
    if (rx_valid) rxv_cyc++;
    if (rx_valid && !prev_rxv) begin
      rx_hist[rxv_cnt] = rx_data;
      rxv_cnt++;
    end
    if (tx_ready && !prev_rdy) gap_seen = hi_ssel;
    prev_ssel = ssel;
    prev_sck = sck;
    prev_rxv = rx_valid;
    prev_rdy = tx_ready;
  end
  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    while (!tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_ready: tx_ready=%b want 1 within 500 cycles", tx_ready);
    end
    tx_data = d;
    tx_last = l;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask
  task automatic wait_rx(input int target, input string tag);
    int n = 0;
    while (rxv_cnt < target && n < 1000) begin
      @(negedge clk);
      #1 n++;
    end
    if (rxv_cnt < target) begin
      vectors++;
      miscompares++;
      $display("FAIL %s rx_timeout: rx pulses=%0d want %0d", tag, rxv_cnt, target);
    end
  endtask
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!tx_ready && n < 500) begin
      @(negedge clk);
      #1 n++;
    end
    if (!tx_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL %s ready_timeout: tx_ready=%b want 1", tag, tx_ready);
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if ({ssel, sck, mosi, tx_ready, rx_valid, busy} !== 6'b100100) begin
        miscompares++;
        $display("FAIL reset_idle cycle %0d: ssel,sck,mosi,rdy,rxv,busy=%b want 100100", i, {ssel, sck, mosi, tx_ready, rx_valid, busy});
      end
    end
    vectors++;
    if (rx_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_rx_data: got %h want 00", rx_data);
    end
  endtask
  task automatic test_single;
    int r0 = sck_rises, h0 = hi_bad, l0 = lo_bad, v0 = rxv_cnt, c0 = rxv_cyc, m0 = mosi_cnt;
    slave_data[mosi_cnt] = 8'h3C;
    send(8'hA5, 1'b1);
    wait_rx(v0 + 1, "single");
    wait_ready("single");
    vectors++;
    if (mosi_hist[m0] !== 8'hA5) begin
      miscompares++;
      $display("FAIL single_mosi: got %h want a5", mosi_hist[m0]);
    end
    vectors++;
    if (sck_rises - r0 !== 8) begin
      miscompares++;
      $display("FAIL single_sck_pulses: got %0d want 8", sck_rises - r0);
    end
    vectors++;
    if (hi_bad - h0 !== 0 || lo_bad - l0 !== 0) begin
      miscompares++;
      $display("FAIL single_sck_width: bad high=%0d bad low=%0d want 0,0", hi_bad - h0, lo_bad - l0);
    end
    vectors++;
    if (ssel_run !== 72) begin
      miscompares++;
      $display("FAIL single_ssel_low: got %0d cycles want 72", ssel_run);
    end
    vectors++;
    if (rx_hist[v0] !== 8'h3C || rxv_cyc - c0 !== 1) begin
      miscompares++;
      $display("FAIL single_rx: data=%h cycles=%0d want 3c,1", rx_hist[v0], rxv_cyc - c0);
    end
    vectors++;
    if (gap_seen < 4) begin
      miscompares++;
      $display("FAIL single_gap: ssel high %0d cycles before ready, want >=4", gap_seen);
    end
  endtask
  task automatic test_burst;
    int r0 = sck_rises, s0 = ssel_rises, v0 = rxv_cnt, m0 = mosi_cnt;
    slave_data[mosi_cnt] = 8'h0A;
    slave_data[mosi_cnt+1] = 8'h81;
    send(8'h05, 1'b0);
    wait_rx(v0 + 1, "burst1");
    wait_ready("burst1");
    vectors++;
    if (ssel !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL burst_wait: ssel=%b busy=%b want 0,1", ssel, busy);
    end
    send(8'hFF, 1'b1);
    wait_rx(v0 + 2, "burst2");
    wait_ready("burst2");
    vectors++;
    if (sck_rises - r0 !== 16 || ssel_rises - s0 !== 1) begin
      miscompares++;
      $display("FAIL burst_framing: sck=%0d ssel_rises=%0d want 16,1", sck_rises - r0, ssel_rises - s0);
    end
    vectors++;
    if (rx_hist[v0] !== 8'h0A || rx_hist[v0+1] !== 8'h81) begin
      miscompares++;
      $display("FAIL burst_rx: got %h,%h want 0a,81", rx_hist[v0], rx_hist[v0+1]);
    end
    vectors++;
    if (mosi_hist[m0] !== 8'h05 || mosi_hist[m0+1] !== 8'hFF) begin
      miscompares++;
      $display("FAIL burst_mosi: got %h,%h want 05,ff", mosi_hist[m0], mosi_hist[m0+1]);
    end
  endtask
  task automatic test_wait_stall;
    int v0 = rxv_cnt, m0 = mosi_cnt, bad = 0;
    slave_data[mosi_cnt] = 8'h34;
    slave_data[mosi_cnt+1] = 8'h6B;
    send(8'h12, 1'b0);
    wait_rx(v0 + 1, "stall1");
    wait_ready("stall1");
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ssel !== 1'b0 || sck !== 1'b0 || tx_ready !== 1'b1) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL stall_hold: %0d bad cycles of 50 want 0", bad);
    end
    send(8'h9E, 1'b1);
    wait_rx(v0 + 2, "stall2");
    wait_ready("stall2");
    vectors++;
    if (rx_hist[v0] !== 8'h34 || rx_hist[v0+1] !== 8'h6B) begin
      miscompares++;
      $display("FAIL stall_rx: got %h,%h want 34,6b", rx_hist[v0], rx_hist[v0+1]);
    end
    vectors++;
    if (mosi_hist[m0] !== 8'h12 || mosi_hist[m0+1] !== 8'h9E) begin
      miscompares++;
      $display("FAIL stall_mosi: got %h,%h want 12,9e", mosi_hist[m0], mosi_hist[m0+1]);
    end
  endtask
  task automatic test_reset_mid;
    int r0 = sck_rises, v0, m0, n = 0;
    slave_data[mosi_cnt] = 8'h77;
    v0 = rxv_cnt;
    send(8'hF0, 1'b1);
    while (sck_rises < r0 + 4 && n < 500) begin
      @(negedge clk);
      #1 n++;
    end
    vectors++;
    if (sck_rises < r0 + 4) begin
      miscompares++;
      $display("FAIL rstmid_timeout: sck rises=%0d want 4", sck_rises - r0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({ssel, sck, mosi, rx_valid, tx_ready, busy} !== 6'b100010) begin
      miscompares++;
      $display("FAIL rstmid_abort: ssel,sck,mosi,rxv,rdy,busy=%b want 100010", {ssel, sck, mosi, rx_valid, tx_ready, busy});
    end
    rst = 1'b0;
    repeat (100) @(negedge clk);
    #1;
    vectors++;
    if (rxv_cnt !== v0) begin
      miscompares++;
      $display("FAIL rstmid_no_rx: pulses=%0d want %0d", rxv_cnt, v0);
    end
    m0 = mosi_cnt;
    slave_data[mosi_cnt] = 8'h99;
    send(8'h55, 1'b1);
    wait_rx(v0 + 1, "rstmid");
    wait_ready("rstmid");
    vectors++;
    if (rx_hist[v0] !== 8'h99 || mosi_hist[m0] !== 8'h55 || ssel_run !== 72) begin
      miscompares++;
      $display("FAIL rstmid_resume: rx=%h mosi=%h ssel_low=%0d want 99,55,72", rx_hist[v0], mosi_hist[m0], ssel_run);
    end
  endtask
  task automatic test_clkdiv2;
    logic prev = 1'b0, got = 1'b0;
    logic [7:0] rx = '0;
    int last_rise = -1, rises = 0, hi = 0, per_bad = 0;
    @(negedge clk);
    d2_data = 8'hC3;
    d2_last = 1'b1;
    d2_valid = 1'b1;
    @(posedge clk);
    #1 d2_valid = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (d2_sck && !prev) begin
        if (last_rise >= 0 && n - last_rise != 4) per_bad++;
        last_rise = n;
        rises++;
      end
      if (d2_sck) hi++;
      prev = d2_sck;
      if (d2_rxv) begin
        got = 1'b1;
        rx = d2_rx;
      end
    end
    vectors++;
    if (!got || rx !== 8'hC3) begin
      miscompares++;
      $display("FAIL div2_rx: got=%b data=%h want 1,c3", got, rx);
    end
    vectors++;
    if (rises !== 8 || per_bad !== 0 || hi !== 16) begin
      miscompares++;
      $display("FAIL div2_sck: rises=%0d bad_periods=%0d high_cycles=%0d want 8,0,16", rises, per_bad, hi);
    end
  endtask
  initial begin
    test_reset;
    test_single;
    test_burst;
    test_wait_stall;
    test_reset_mid;
    test_clkdiv2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
